apple_ctrl: RTL



---
 rtl/snake_pkg.sv | 22 ++
 rtl/apple_ctrl_lfsr16.sv | 25 ++
 rtl/apple_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: game status codes, grid defaults,
// apple FSM states and the apple LFSR tap mask.
package snake_pkg;

    localparam logic [1:0] ST_RESTART = 2'b00;
    localparam logic [1:0] ST_PLAY    = 2'b01;
    localparam logic [1:0] ST_PAUSE   = 2'b10;
    localparam logic [1:0] ST_DIE     = 2'b11;

    localparam int DEF_GRID_W  = 40;
    localparam int DEF_GRID_H  = 30;
    localparam int DEF_COORD_W = 6;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SPAWN,
        ACTIVE,
        EATEN
    } apple_state_t;

endpackage

// File: rtl/apple_ctrl_lfsr16.sv
// 16-bit Galois LFSR (right shift) with seed load and step enable.
// Load has priority over enable.
module lfsr16
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (en) begin
            state <= state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
        end
    end

endmodule

// File: rtl/apple_ctrl.sv
// Apple placement, eat detection and score pulses for the snake game.
// Define APPLE_BONUS_EN to enable the quick-eat reward_grade bonus.
module apple_ctrl
    import snake_pkg::*;
#(
    parameter int          GRID_W       = DEF_GRID_W,
    parameter int          GRID_H       = DEF_GRID_H,
    parameter int          COORD_W      = DEF_COORD_W,
    parameter int          BONUS_FRAMES = 20,
    parameter int          PULSE_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         game_status,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    output logic [COORD_W-1:0] apple_x,
    output logic [COORD_W-1:0] apple_y,
    output logic               apple_valid,
    output logic               add_cube,
    output logic               reward_grade
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LD = PW'(PULSE_CYCLES);
    localparam logic [COORD_W-1:0] GW = COORD_W'(GRID_W);
    localparam logic [COORD_W-1:0] GH = COORD_W'(GRID_H);

    apple_state_t       state_q, state_d;
    logic [COORD_W-1:0] ax_q, ax_d, ay_q, ay_d;
    logic               valid_q, valid_d;
    logic               add_q, add_d;
    logic               rew_q, rew_d;
    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic [15:0]        lfsr;
    logic               unused_lfsr;
    logic               restart, play, accept, hit, bonus_ok;
    logic [COORD_W-1:0] cx, cy;

    assign restart = (game_status == ST_RESTART);
    assign play    = (game_status == ST_PLAY);

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (restart),
        .en    (1'b1),
        .state (lfsr)
    );

    // Candidate fields; upper LFSR bits only feed the sequence
    assign cx          = lfsr[COORD_W-1:0];
    assign cy          = lfsr[2*COORD_W-1:COORD_W];
    assign unused_lfsr = ^lfsr;

    assign accept = (cx < GW) && (cy < GH)
                 && !((cx == head_x) && (cy == head_y));
    assign hit    = (head_x == ax_q) && (head_y == ay_q);

`ifdef APPLE_BONUS_EN
    localparam int BW = $clog2(BONUS_FRAMES + 1);
    localparam logic [BW-1:0] BONUS_MAX = BW'(BONUS_FRAMES);
    logic [BW-1:0] bcnt_q, bcnt_d;
    assign bonus_ok = (bcnt_q < BONUS_MAX);
`else
    assign bonus_ok = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        valid_d = valid_q;
        add_d   = add_q;
        rew_d   = rew_q;
        pcnt_d  = pcnt_q;
`ifdef APPLE_BONUS_EN
        bcnt_d  = bcnt_q;
`endif
        unique case (state_q)
            SPAWN: begin
                if (play && accept) begin
                    ax_d    = cx;
                    ay_d    = cy;
                    valid_d = 1'b1;
                    state_d = ACTIVE;
`ifdef APPLE_BONUS_EN
                    bcnt_d  = '0;
`endif
                end
            end
            ACTIVE: begin
                if (play && frame_tick) begin
                    if (hit) begin
                        valid_d = 1'b0;
                        pcnt_d  = PULSE_LD;
                        add_d   = 1'b1;
                        rew_d   = bonus_ok;
                        state_d = EATEN;
                    end
`ifdef APPLE_BONUS_EN
                    else if (bcnt_q != BONUS_MAX) begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
`endif
                end
            end
            EATEN: begin
                // Runs regardless of game status so a started pulse completes
                if (pcnt_q <= PW'(1)) begin
                    pcnt_d  = '0;
                    add_d   = 1'b0;
                    rew_d   = 1'b0;
                    state_d = SPAWN;
                end else begin
                    pcnt_d = pcnt_q - PW'(1);
                end
            end
            default: state_d = SPAWN;
        endcase
        if (restart) begin
            state_d = SPAWN;
            ax_d    = '0;
            ay_d    = '0;
            valid_d = 1'b0;
            add_d   = 1'b0;
            rew_d   = 1'b0;
            pcnt_d  = '0;
`ifdef APPLE_BONUS_EN
            bcnt_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SPAWN;
            ax_q    <= '0;
            ay_q    <= '0;
            valid_q <= 1'b0;
            add_q   <= 1'b0;
            rew_q   <= 1'b0;
            pcnt_q  <= '0;
`ifdef APPLE_BONUS_EN
            bcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            valid_q <= valid_d;
            add_q   <= add_d;
            rew_q   <= rew_d;
            pcnt_q  <= pcnt_d;
`ifdef APPLE_BONUS_EN
            bcnt_q  <= bcnt_d;
`endif
        end
    end

    assign apple_x      = ax_q;
    assign apple_y      = ay_q;
    assign apple_valid  = valid_q;
    assign add_cube     = add_q;
    assign reward_grade = rew_q;

endmodule
